// File: rtl/pipe_hazard_unit_if.sv
// Decode/EX side handshake bundle for pipe_hazard_unit: instruction descriptors in,
// issue/stall/flush/forwarding controls out.
interface pipe_hazard_unit_if #(
  parameter int REG_ADDR_W = 2,
  parameter int SEL_W      = 2
);
  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_src1_used;
  logic                  id_src2_used;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_dst_wr;
  logic                  id_is_load;
  logic                  id_is_branch;
  logic                  ex_br_valid;
  logic                  ex_br_taken;

  logic                  issue;
  logic                  stall;
  logic                  pc_hold;
  logic                  flush;
  logic [NUM_REGS-1:0]   busy_map;
  logic [SEL_W-1:0]      fwd_sel1;
  logic [SEL_W-1:0]      fwd_sel2;

  modport master (
    output id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
           id_dst, id_dst_wr, id_is_load, id_is_branch, ex_br_valid, ex_br_taken,
    input  issue, stall, pc_hold, flush, busy_map, fwd_sel1, fwd_sel2
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
           id_dst, id_dst_wr, id_is_load, id_is_branch, ex_br_valid, ex_br_taken,
    output issue, stall, pc_hold, flush, busy_map, fwd_sel1, fwd_sel2
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Issue/hazard controller: destination-tag pipe, RAW stall, branch serialisation and flush.
// Define PIPE_HAZARD_FWD_EN to enable forwarding selects (stall only on load-use).
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int FLUSH_CYC  = 2,
  parameter int SEL_W      = 2
) (
  input  logic              clock,
  input  logic              reset,
  pipe_hazard_unit_if.slave hz
);
  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int CNT_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic [PIPE_DEPTH-1:0] vld_p;
  logic [REG_ADDR_W-1:0] dst_p [PIPE_DEPTH];

  logic [PIPE_DEPTH-1:0] m1, m2;
  logic [NUM_REGS-1:0]   busy_c;
  logic                  hazard, issue_c, stall_c, flush_c;

  // Per-entry source matches; entry k sits k+1 stages past issue
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      m1[k] = hz.id_src1_used & vld_p[k] & (dst_p[k] == hz.id_src1);
      m2[k] = hz.id_src2_used & vld_p[k] & (dst_p[k] == hz.id_src2);
    end
  end

  always_comb begin
    busy_c = '0;
    for (int k = 0; k < PIPE_DEPTH; k++)
      if (vld_p[k]) busy_c[dst_p[k]] = 1'b1;
  end

`ifdef PIPE_HAZARD_FWD_EN
  logic [PIPE_DEPTH-1:0] ld_p;

  function automatic logic [SEL_W-1:0] youngest_sel(input logic [PIPE_DEPTH-1:0] m);
    youngest_sel = '0;
    for (int k = PIPE_DEPTH-1; k >= 0; k--)
      if (m[k]) youngest_sel = SEL_W'(k + 1);
  endfunction

  // Only a load still in EX cannot be forwarded
  assign hazard      = ld_p[0] & (m1[0] | m2[0]);
  assign hz.fwd_sel1 = stall_c ? '0 : youngest_sel(m1);
  assign hz.fwd_sel2 = stall_c ? '0 : youngest_sel(m2);

  always_ff @(posedge clock) begin
    ld_p <= {ld_p[PIPE_DEPTH-2:0], hz.id_is_load};
  end
`else
  logic unused_is_load;

  // Without forwarding the consumer waits until the producer has written the RF
  assign hazard         = |m1 | |m2;
  assign hz.fwd_sel1    = '0;
  assign hz.fwd_sel2    = '0;
  assign unused_is_load = hz.id_is_load;
`endif

  assign issue_c     = hz.id_valid & (state == RUN) & ~hazard;
  assign stall_c     = (hz.id_valid & ~issue_c) | (state != RUN);
  assign flush_c     = (state == FLUSH);
  assign hz.issue    = issue_c;
  assign hz.stall    = stall_c;
  assign hz.flush    = flush_c;
  assign hz.pc_hold  = stall_c & ~flush_c;
  assign hz.busy_map = busy_c;

  // Tag pipe stage boundary: entry 0 = EX ... entry PIPE_DEPTH-1 = WB
  always_ff @(posedge clock) begin
    if (reset) vld_p <= '0;
    else       vld_p <= {vld_p[PIPE_DEPTH-2:0], issue_c & hz.id_dst_wr};
  end

  always_ff @(posedge clock) begin
    dst_p[0] <= hz.id_dst;
    for (int k = 1; k < PIPE_DEPTH; k++) dst_p[k] <= dst_p[k-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN:     if (issue_c && hz.id_is_branch) state_nxt = BR_WAIT;
      BR_WAIT: if (hz.ex_br_valid) begin
        if (hz.ex_br_taken) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_W'(FLUSH_CYC - 1);
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH:   if (cnt == '0) state_nxt = RUN;
               else           cnt_nxt   = cnt - CNT_W'(1);
      default: state_nxt = RUN;
    endcase
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit (REG_ADDR_W=2, PIPE_DEPTH=3, FLUSH_CYC=2);
// forwarding vectors are selected by PIPE_HAZARD_FWD_EN.
module tb_pipe_hazard_unit;
  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  pipe_hazard_unit_if #(.REG_ADDR_W(2), .SEL_W(2)) hz ();

  pipe_hazard_unit #(
    .REG_ADDR_W(2), .PIPE_DEPTH(3), .FLUSH_CYC(2), .SEL_W(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hz   (hz)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_instr(input logic v, input logic [1:0] s1, input logic s1u,
                           input logic [1:0] s2, input logic s2u, input logic [1:0] d,
                           input logic wr, input logic ld, input logic br);
    hz.id_valid     = v;
    hz.id_src1      = s1;
    hz.id_src1_used = s1u;
    hz.id_src2      = s2;
    hz.id_src2_used = s2u;
    hz.id_dst       = d;
    hz.id_dst_wr    = wr;
    hz.id_is_load   = ld;
    hz.id_is_branch = br;
  endtask

  task automatic set_br(input logic v, input logic t);
    hz.ex_br_valid = v;
    hz.ex_br_taken = t;
  endtask

  task automatic idle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_br(0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    settle();
    check_eq("rst_issue",   hz.issue,    0);
    check_eq("rst_stall",   hz.stall,    0);
    check_eq("rst_pc_hold", hz.pc_hold,  0);
    check_eq("rst_flush",   hz.flush,    0);
    check_eq("rst_busy",    hz.busy_map, 0);
    check_eq("rst_fwd1",    hz.fwd_sel1, 0);
    check_eq("rst_fwd2",    hz.fwd_sel2, 0);
    tick();

`ifndef PIPE_HAZARD_FWD_EN
    // RAW on r1: consumer waits three cycles while r1 travels EX..WB
    set_instr(1, 0, 0, 0, 0, 1, 1, 0, 0);
    settle();
    check_eq("raw_prod_issue", hz.issue, 1);
    tick();
    set_instr(1, 1, 1, 0, 0, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("raw_stall",   hz.stall,    1);
      check_eq("raw_noissue", hz.issue,    0);
      check_eq("raw_pc_hold", hz.pc_hold,  1);
      check_eq("raw_busy",    hz.busy_map, 4'b0010);
      check_eq("raw_fwd1",    hz.fwd_sel1, 0);
      tick();
    end
    settle();
    check_eq("raw_issue4",  hz.issue,    1);
    check_eq("raw_stall4",  hz.stall,    0);
    check_eq("raw_busy4",   hz.busy_map, 0);
    tick();
    idle();
    settle();
    check_eq("busy_r2", hz.busy_map, 4'b0100);
    tick();
    tick();
    tick();
    settle();
    check_eq("busy_drained", hz.busy_map, 0);

    // Same reg on both sources with itself as dst, then used-flag gating, then src2 RAW
    set_instr(1, 3, 1, 3, 1, 3, 1, 0, 0);
    settle();
    check_eq("self_no_hazard", hz.issue, 1);
    tick();
    set_instr(1, 3, 0, 0, 1, 0, 0, 0, 0);
    settle();
    check_eq("unused_src_issue", hz.issue, 1);
    tick();
    set_instr(1, 0, 0, 3, 1, 0, 0, 0, 0);
    settle();
    check_eq("src2_raw_stall_a", hz.stall, 1);
    tick();
    settle();
    check_eq("src2_raw_stall_b", hz.stall, 1);
    tick();
    settle();
    check_eq("src2_raw_issue", hz.issue, 1);
    tick();
    idle();
    tick();
`else
    // Back-to-back producer/consumer forwards from EX
    set_instr(1, 0, 0, 0, 0, 2, 1, 0, 0);
    settle();
    check_eq("fwd_prod_issue", hz.issue, 1);
    tick();
    set_instr(1, 0, 0, 2, 1, 0, 0, 0, 0);
    settle();
    check_eq("fwd_issue",  hz.issue,    1);
    check_eq("fwd_stall",  hz.stall,    0);
    check_eq("fwd_sel2_1", hz.fwd_sel2, 1);
    check_eq("fwd_sel1_0", hz.fwd_sel1, 0);
    tick();
    idle();
    tick();
    tick();
    // One bubble between producer and consumer
    set_instr(1, 0, 0, 0, 0, 2, 1, 0, 0);
    tick();
    idle();
    tick();
    set_instr(1, 0, 0, 2, 1, 0, 0, 0, 0);
    settle();
    check_eq("gap_stall",  hz.stall,    0);
    check_eq("gap_sel2_2", hz.fwd_sel2, 2);
    tick();
    idle();
    tick();
    tick();
    tick();
    // Load-use: one stall, then forward from the stage after EX
    set_instr(1, 0, 0, 0, 0, 3, 1, 1, 0);
    settle();
    check_eq("ld_issue", hz.issue, 1);
    tick();
    set_instr(1, 3, 1, 0, 0, 0, 0, 0, 0);
    settle();
    check_eq("lu_stall",  hz.stall,    1);
    check_eq("lu_sel1_0", hz.fwd_sel1, 0);
    tick();
    settle();
    check_eq("lu_issue",  hz.issue,    1);
    check_eq("lu_sel1_2", hz.fwd_sel1, 2);
    tick();
    idle();
    tick();
    tick();
    tick();
    // Two producers of r1 in flight: youngest wins
    set_instr(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    tick();
    set_instr(1, 1, 1, 0, 0, 0, 0, 0, 0);
    settle();
    check_eq("young_sel1", hz.fwd_sel1, 1);
    check_eq("young_busy", hz.busy_map, 4'b0010);
    tick();
    idle();
    tick();
    tick();
    tick();
`endif

    // Taken branch: wait a cycle, resolve taken, flush exactly two cycles
    set_instr(1, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    check_eq("bt_issue", hz.issue, 1);
    tick();
    set_instr(1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check_eq("bw_stall",   hz.stall,   1);
    check_eq("bw_flush",   hz.flush,   0);
    check_eq("bw_pc_hold", hz.pc_hold, 1);
    tick();
    set_br(1, 1);
    settle();
    check_eq("bt_res_stall", hz.stall, 1);
    check_eq("bt_res_flush", hz.flush, 0);
    tick();
    set_br(0, 0);
    settle();
    check_eq("fl1_flush",   hz.flush,   1);
    check_eq("fl1_stall",   hz.stall,   1);
    check_eq("fl1_pc_hold", hz.pc_hold, 0);
    check_eq("fl1_issue",   hz.issue,   0);
    tick();
    settle();
    check_eq("fl2_flush",   hz.flush,   1);
    check_eq("fl2_pc_hold", hz.pc_hold, 0);
    tick();
    set_br(1, 1);
    settle();
    check_eq("fl_done_flush", hz.flush, 0);
    check_eq("fl_done_issue", hz.issue, 1);
    tick();
    idle();
    settle();
    check_eq("br_ignored_flush", hz.flush, 0);
    check_eq("br_ignored_stall", hz.stall, 0);
    tick();

    // Not-taken branch releases the waiting instruction
    set_instr(1, 0, 0, 0, 0, 0, 0, 0, 1);
    settle();
    check_eq("bn_issue", hz.issue, 1);
    tick();
    set_instr(1, 0, 0, 0, 0, 0, 0, 0, 0);
    set_br(1, 0);
    settle();
    check_eq("bn_stall", hz.stall, 1);
    check_eq("bn_flush", hz.flush, 0);
    tick();
    set_br(0, 0);
    settle();
    check_eq("bn_next_issue", hz.issue, 1);
    check_eq("bn_next_flush", hz.flush, 0);
    tick();
    idle();
    tick();

    // Reset during FLUSH with a branch tag still in the pipe
    set_instr(1, 0, 0, 0, 0, 2, 1, 0, 1);
    settle();
    check_eq("rf_br_issue", hz.issue, 1);
    tick();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_br(1, 1);
    tick();
    set_br(0, 0);
    settle();
    check_eq("rf_in_flush", hz.flush, 1);
    reset = 1'b1;
    tick();
    settle();
    check_eq("rf_rst_flush", hz.flush,    0);
    check_eq("rf_rst_busy",  hz.busy_map, 0);
    tick();
    reset = 1'b0;
    settle();
    check_eq("rf_flush", hz.flush,    0);
    check_eq("rf_stall", hz.stall,    0);
    check_eq("rf_busy",  hz.busy_map, 0);
    set_instr(1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    check_eq("rf_run_issue", hz.issue, 1);
    tick();
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
